// File: rtl/tpum_pkg.sv
// Shared types and defaults for the TPUM XBOX row responder.
package tpum_pkg;

  localparam int TPUM_ROW_BITS  = 1024;
  localparam int TPUM_WORD_BITS = 32;

  // One-hot so each state bit can be probed directly from dbg_state.
  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_RD_ISSUE = 5'b00010,
    S_RD_DRAIN = 5'b00100,
    S_WR_ISSUE = 5'b01000,
    S_RSP      = 5'b10000
  } xbox_rsp_state_t;

  // A row must start on a beats-per-row word boundary.
  function automatic logic addr_misaligned(input logic [31:0] addr, input int beats);
    return (addr % 32'(beats)) != 32'd0;
  endfunction

endpackage

// File: rtl/tpum_row_assembler.sv
// Row buffer with beat counter: loads a full row, selects the current beat for
// writes, and captures returning read words one cycle after their issue beat.
module tpum_row_assembler
  import tpum_pkg::*;
#(
  parameter  int ROW_BITS  = TPUM_ROW_BITS,
  parameter  int WORD_BITS = TPUM_WORD_BITS,
  localparam int BEATS     = ROW_BITS / WORD_BITS,
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [ROW_BITS-1:0]  i_load_row,
  input  logic                 i_step,
  input  logic                 i_capture,
  input  logic [WORD_BITS-1:0] i_cap_word,
  output logic [CNT_BITS-1:0]  o_k,
  output logic                 o_last,
  output logic [WORD_BITS-1:0] o_sel_word,
  output logic [ROW_BITS-1:0]  o_row
);

  localparam logic [CNT_BITS-1:0] LAST_K = CNT_BITS'(BEATS - 1);

  logic [CNT_BITS-1:0] r_k;
  logic [CNT_BITS-1:0] r_cap_idx;
  logic                r_cap_pend;
  logic [ROW_BITS-1:0] r_row;

  // The counter saturates at the last beat; the FSM leaves the issue state there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k <= '0;
    end else if (i_load) begin
      r_k <= '0;
    end else if (i_step && (r_k != LAST_K)) begin
      r_k <= r_k + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_pend <= 1'b0;
      r_cap_idx  <= '0;
    end else begin
      r_cap_pend <= i_step && i_capture;
      r_cap_idx  <= r_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (i_load) begin
      r_row <= i_load_row;
    end else if (r_cap_pend) begin
      r_row[int'(r_cap_idx)*WORD_BITS +: WORD_BITS] <= i_cap_word;
    end
  end

  assign o_k        = r_k;
  assign o_last     = (r_k == LAST_K);
  assign o_sel_word = r_row[int'(r_k)*WORD_BITS +: WORD_BITS];
  assign o_row      = r_row;

endmodule

// File: rtl/tpum_xbox_responder.sv
// XBOX-side responder: serves row reads/writes from the TPUM control FSM as
// word beats on a 1-cycle-latency single-port SRAM, one response per request.
module tpum_xbox_responder
  import tpum_pkg::*;
#(
  parameter  int ROW_BITS  = TPUM_ROW_BITS,
  parameter  int WORD_BITS = TPUM_WORD_BITS,
  parameter  int ADDR_BITS = 32,
  parameter  int MEM_WORDS = 65536,
  localparam int BEATS     = ROW_BITS / WORD_BITS,
  localparam int CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable from valid until that edge.
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [ROW_BITS-1:0]  req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic                 rsp_err,
  output logic [ROW_BITS-1:0]  rsp_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD_BITS-1:0] mem_wdata,
  input  logic [WORD_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic [4:0]           dbg_state
);

  xbox_rsp_state_t r_state;
  xbox_rsp_state_t w_next;

  logic [ADDR_BITS-1:0] r_base;
  logic                 r_write;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_req_err;
  logic                 w_oob;
  logic [ADDR_BITS:0]   w_end;
  logic                 w_rd_beat;
  logic                 w_wr_beat;
  logic [CNT_BITS-1:0]  w_k;
  logic                 w_last;
  logic [WORD_BITS-1:0] w_sel_word;
  logic [ROW_BITS-1:0]  w_row;
  logic [ROW_BITS-1:0]  w_load_row;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // The extra top bit keeps base + BEATS from wrapping near the top of the address space.
  assign w_end     = {1'b0, req_addr} + (ADDR_BITS+1)'(BEATS);
  assign w_oob     = w_end > (ADDR_BITS+1)'(MEM_WORDS);
  assign w_req_err = addr_misaligned(32'(req_addr), BEATS) || w_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base  <= req_addr;
        r_write <= req_write;
        r_err   <= w_req_err;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_rd_beat = 1'b0;
    w_wr_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err)      w_next = S_RSP;
          else if (req_write) w_next = S_WR_ISSUE;
          else                w_next = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        w_rd_beat = 1'b1;
        if (w_last) w_next = S_RD_DRAIN;
      end
      S_RD_DRAIN: w_next = S_RSP;
      S_WR_ISSUE: begin
        w_wr_beat = 1'b1;
        if (w_last) w_next = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The buffer doubles as write source and read destination; reads start from zero.
  assign w_load_row = req_write ? req_wdata : '0;

  tpum_row_assembler #(
    .ROW_BITS  (ROW_BITS),
    .WORD_BITS (WORD_BITS)
  ) u_row (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_row (w_load_row),
    .i_step     (w_rd_beat || w_wr_beat),
    .i_capture  (w_rd_beat),
    .i_cap_word (mem_rdata),
    .o_k        (w_k),
    .o_last     (w_last),
    .o_sel_word (w_sel_word),
    .o_row      (w_row)
  );

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  assign mem_en    = w_rd_beat || w_wr_beat;
  assign mem_we    = w_wr_beat;
  assign mem_addr  = mem_en ? (r_base + ADDR_BITS'(w_k)) : '0;
  assign mem_wdata = w_wr_beat ? w_sel_word : '0;

  assign rsp_valid = (r_state == S_RSP);
  assign rsp_write = rsp_valid && r_write;
  assign rsp_err   = rsp_valid && r_err;
  // Write responses carry no data even though the buffer still holds the write row.
  assign rsp_rdata = r_write ? '0 : w_row;

endmodule

// File: tb/tb_tpum_xbox_responder.sv
// Directed bench for tpum_xbox_responder with a behavioural 1-cycle SRAM and a
// response scoreboard.
module tb_tpum_xbox_responder;

  localparam int ROW_BITS  = 1024;
  localparam int WORD_BITS = 32;
  localparam int ADDR_BITS = 32;
  localparam int MEM_WORDS = 65536;
  localparam int BEATS     = ROW_BITS / WORD_BITS;
  localparam int W         = ROW_BITS + 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_write = 1'b0;
  logic [ADDR_BITS-1:0] req_addr = '0;
  logic [ROW_BITS-1:0]  req_wdata = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic                 rsp_write;
  logic                 rsp_err;
  logic [ROW_BITS-1:0]  rsp_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_wdata;
  logic [WORD_BITS-1:0] mem_rdata;
  logic                 busy;
  logic [4:0]           dbg_state;

  logic [W-1:0] exp_q[$];
  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [WORD_BITS-1:0] mem [0:MEM_WORDS-1];
  logic [WORD_BITS-1:0] mem_q = '0;

  tpum_xbox_responder #(
    .ROW_BITS  (ROW_BITS),
    .WORD_BITS (WORD_BITS),
    .ADDR_BITS (ADDR_BITS),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / SRAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[15:0]] = mem_wdata;
      else        mem_q <= mem[mem_addr[15:0]];
    end
  end
  assign mem_rdata = mem_q;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [ROW_BITS-1:0] ramp_row(input logic [31:0] base);
    logic [ROW_BITS-1:0] r;
    for (int k = 0; k < BEATS; k++) r[k*WORD_BITS +: WORD_BITS] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [ROW_BITS-1:0] wr_pattern();
    logic [ROW_BITS-1:0] r;
    for (int k = 0; k < BEATS; k++) r[k*WORD_BITS +: WORD_BITS] = 32'hA500_0000 | 32'(k);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected response and compares the whole response bundle.
  task automatic check_rsp(input string tag);
    logic [W-1:0] exp;
    logic [W-1:0] obs;
    int bad;
    cmp_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $error("FAIL %s: response with empty expected queue", tag);
      return;
    end
    exp = exp_q.pop_front();
    obs = {rsp_write, rsp_err, rsp_rdata};
    assert (obs === exp) else begin
      err_cnt++;
      bad = 0;
      for (int b = BEATS - 1; b >= 0; b--)
        if (obs[b*WORD_BITS +: WORD_BITS] !== exp[b*WORD_BITS +: WORD_BITS]) bad = b;
      $error("FAIL %s: write/err got %b%b expected %b%b, beat %0d got %h expected %h", tag,
             obs[W-1], obs[W-2], exp[W-1], exp[W-2], bad,
             obs[bad*WORD_BITS +: WORD_BITS], exp[bad*WORD_BITS +: WORD_BITS]);
    end
  endtask

  // Drives one request, then watches SRAM traffic until the first rsp_valid cycle.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [ROW_BITS-1:0] wdata,
                         input logic early_rdy, output int rsp_cyc, output int strobes,
                         output int addr_bad, output int we_cnt, output logic [31:0] beat5);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = early_rdy;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = '0;
    rsp_cyc = -1; strobes = 0; addr_bad = 0; we_cnt = 0; beat5 = '0;
    for (int n = 1; n <= 100 && rsp_cyc < 0; n++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cyc = n;
      else if (mem_en) begin
        if (mem_addr !== addr + 32'(strobes)) addr_bad++;
        if (mem_we) we_cnt++;
        if (strobes == 5) beat5 = mem_wdata;
        strobes++;
      end
    end
    if (rsp_cyc < 0) begin
      cmp_cnt++;
      err_cnt++;
      $error("FAIL rsp_timeout: no rsp_valid within 100 cycles for addr %h", addr);
    end
  endtask

  // Called at a negedge while rsp_valid is high: score it and complete the handshake.
  task automatic finish_rsp(input string tag);
    check_rsp(tag);
    check({tag, "_mem_en_in_rsp"}, 64'(mem_en), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_req_ready_after"}, 64'(req_ready), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int rc, st, ab, wc, strobes;
  logic [31:0] b5;
  logic [31:0] err_addr [5];
  logic        err_wr   [5];

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i);
    err_addr = '{32'h21, 32'hFFF0, 32'h1_0000, 32'hFFFF_FFE0, 32'h21};
    err_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset then idle
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_rsp_rdata_zero", 64'(rsp_rdata == '0), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_mem_en", 64'(mem_en), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_mem_addr", 64'(mem_addr), 64'd0);
    check("idle_state", 64'(dbg_state), 64'd1);

    // read at 0x40
    exp_q.push_back({1'b0, 1'b0, ramp_row(32'h40)});
    run_req(1'b0, 32'h40, '0, 1'b0, rc, st, ab, wc, b5);
    check("rd40_cycle", 64'(rc), 64'd34);
    check("rd40_strobes", 64'(st), 64'd32);
    check("rd40_addr_sweep_bad", 64'(ab), 64'd0);
    check("rd40_we", 64'(wc), 64'd0);
    check("rd40_lsw", 64'(rsp_rdata[31:0]), 64'h40);
    check("rd40_msw", 64'(rsp_rdata[1023:992]), 64'h5F);
    check("rd40_err", 64'(rsp_err), 64'd0);
    finish_rsp("rd40");

    // write at 0x20, then read it back
    exp_q.push_back({1'b1, 1'b0, {ROW_BITS{1'b0}}});
    run_req(1'b1, 32'h20, wr_pattern(), 1'b0, rc, st, ab, wc, b5);
    check("wr20_cycle", 64'(rc), 64'd33);
    check("wr20_strobes", 64'(st), 64'd32);
    check("wr20_we", 64'(wc), 64'd32);
    check("wr20_addr_sweep_bad", 64'(ab), 64'd0);
    check("wr20_beat5", 64'(b5), 64'hA500_0005);
    finish_rsp("wr20");

    exp_q.push_back({1'b0, 1'b0, wr_pattern()});
    run_req(1'b0, 32'h20, '0, 1'b0, rc, st, ab, wc, b5);
    check("rb20_cycle", 64'(rc), 64'd34);
    finish_rsp("rb20");

    // rejected requests: misaligned, out of range, wrap-around, misaligned write
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({err_wr[i], 1'b1, {ROW_BITS{1'b0}}});
      run_req(err_wr[i], err_addr[i], wr_pattern(), 1'b0, rc, st, ab, wc, b5);
      check($sformatf("err%0d_cycle", i), 64'(rc), 64'd1);
      check($sformatf("err%0d_strobes", i), 64'(st), 64'd0);
      finish_rsp($sformatf("err%0d", i));
    end

    // last full row in range, with rsp_ready raised before rsp_valid
    exp_q.push_back({1'b0, 1'b0, ramp_row(32'hFFE0)});
    run_req(1'b0, 32'hFFE0, '0, 1'b1, rc, st, ab, wc, b5);
    check("rdtop_cycle", 64'(rc), 64'd34);
    check("rdtop_strobes", 64'(st), 64'd32);
    finish_rsp("rdtop");

    // backpressure: response held 10 cycles while a new request is offered
    exp_q.push_back({1'b0, 1'b0, ramp_row(32'h80)});
    run_req(1'b0, 32'h80, '0, 1'b0, rc, st, ab, wc, b5);
    check("bp_cycle", 64'(rc), 64'd34);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h200;
      req_wdata = wr_pattern();
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_mem_en", 64'(mem_en), 64'd0);
      check("bp_flags", 64'({rsp_write, rsp_err}), 64'd0);
      check("bp_lsw", 64'(rsp_rdata[31:0]), 64'h80);
      check("bp_msw", 64'(rsp_rdata[1023:992]), 64'h9F);
      @(negedge clk);
    end
    req_valid = 1'b0;
    req_wdata = '0;
    finish_rsp("bp");
    check("bp_ignored_write", 64'(mem[32'h200]), 64'h200);

    // reset during beat 10 of a read
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    strobes = 0;
    for (int n = 0; n < 40 && strobes < 11; n++) begin
      @(negedge clk);
      if (mem_en) strobes++;
    end
    check("abort_reached_beat10", 64'(strobes), 64'd11);
    rst_n = 1'b0;
    #1;
    check("abort_mem_en", 64'(mem_en), 64'd0);
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_err", 64'(rsp_err), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rsp_rdata_zero", 64'(rsp_rdata == '0), 64'd1);
    check("abort_state", 64'(dbg_state), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    exp_q.push_back({1'b0, 1'b0, ramp_row(32'h100)});
    run_req(1'b0, 32'h100, '0, 1'b0, rc, st, ab, wc, b5);
    check("rd100_cycle", 64'(rc), 64'd34);
    check("rd100_addr_sweep_bad", 64'(ab), 64'd0);
    finish_rsp("rd100");

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tpum_xbox_responder.md
Name: tpum_xbox_responder

Overview:
- XBOX-side responder serving row-sized read and write requests from the TPUM control FSM, for example R1/R2 loads at base pointers A/B and result write-back at base pointer C.
- Splits each ROW_BITS row into WORD_BITS beats on a word-wide single-port SRAM with 1-cycle read latency.
- Returns one row-wide response per request.
- Sits between the TPUM request channel and the XBOX memory macro.

Parameters:
ROW_BITS, 1024, row width in bits; must be a multiple of WORD_BITS
WORD_BITS, 32, SRAM word width
ADDR_BITS, 32, word-address width
MEM_WORDS, 65536, number of valid SRAM words, used for the range check
BEATS (localparam), ROW_BITS/WORD_BITS, beats per row (32)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  responder can accept a request
req_write  in  1  1 = row write, 0 = row read
req_addr  in  ADDR_BITS  row base word address
req_wdata  in  ROW_BITS  write row data
rsp_valid  out  1  response valid
rsp_ready  in  1  requester accepts response
rsp_write  out  1  echo of the accepted req_write
rsp_err  out  1  request rejected (misaligned or out of range)
rsp_rdata  out  ROW_BITS  read row data (all zeros for writes and errors)
mem_en  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_BITS  SRAM word address
mem_wdata  out  WORD_BITS  SRAM write data
mem_rdata  in  WORD_BITS  SRAM read data, valid the cycle after a read strobe
busy  out  1  asserted in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; beat counter = 0.
  - req_ready = 1; rsp_valid = rsp_write = rsp_err = 0; rsp_rdata = 0.
  - mem_en = mem_we = 0; mem_addr = 0; mem_wdata = 0; busy = 0.
- State machine: one-hot states IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, RSP.
- Request acceptance:
  - req_ready = 1 only in IDLE; a request is accepted on req_valid && req_ready at a rising edge.
  - On acceptance, latch req_addr, req_write and req_wdata; clear rsp_rdata; clear beat counter k.
- Error check, made at acceptance:
  - Error when req_addr % BEATS != 0, or req_addr + BEATS > MEM_WORDS; compute the sum at ADDR_BITS+1 width so it cannot wrap.
  - On error: go directly to RSP with rsp_err = 1; no SRAM access occurs.
- Read path:
  - RD_ISSUE: mem_en = 1, mem_we = 0, mem_addr = base + k for k = 0..BEATS-1, one beat per cycle.
  - The cycle after issuing beat j, capture mem_rdata into rsp_rdata[j*WORD_BITS +: WORD_BITS] (beat 0 = LSBs).
  - After issuing beat BEATS-1, go to RD_DRAIN (mem_en = 0), which captures the last word, then go to RSP.
  - Latency: accept edge at cycle 0, issue in cycles 1..32, drain in cycle 33, rsp_valid first high in cycle 34.
- Write path:
  - WR_ISSUE: mem_en = 1, mem_we = 1, mem_addr = base + k, mem_wdata = wdata[k*WORD_BITS +: WORD_BITS].
  - After beat BEATS-1, go to RSP with rsp_write = 1 and rsp_err = 0; rsp_valid first high in cycle 33.
- Response:
  - In RSP, rsp_valid = 1; rsp_write, rsp_err and rsp_rdata are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; req_ready rises in the following cycle.
  - No request overlap and no new request is accepted while a response is pending.
- Outside active issue beats: mem_en = 0, mem_we = 0.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation aborts the transfer: no response is produced, partial writes already issued remain in SRAM, and rsp_rdata is cleared.
- Beat counter width is $clog2(BEATS); the counter never wraps past BEATS-1.

Decomposition:
- tpum_pkg holds:
  - the state enum xbox_rsp_state_t;
  - the ROW_BITS/WORD_BITS defaults;
  - the alignment-check function.
- One sub-module, tpum_row_assembler: beat counter plus slice-capture and slice-select datapath for the row buffer, shared by the read and write paths.

Test Plan:
- Reset then idle: req_ready=1, rsp_valid=0, mem_en=0, busy=0.
- Read at addr 0x40 with SRAM word n preloaded to n:
  - mem_addr sweeps 0x40..0x5F over cycles 1..32;
  - rsp_valid in cycle 34;
  - rsp_rdata[31:0]=0x40 and rsp_rdata[1023:992]=0x5F;
  - rsp_err=0.
- Write at addr 0x20 with wdata slice k = 0xA5000000|k:
  - 32 strobes with mem_we=1, mem_wdata beat 5 = 0xA5000005;
  - rsp_valid in cycle 33 with rsp_write=1;
  - a subsequent read of 0x20 returns the identical row.
- Misaligned addr 0x21, and addr 0xFFF0 with MEM_WORDS=65536:
  - no mem_en activity;
  - rsp_valid in cycle 1 with rsp_err=1 and rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 10 cycles; rsp fields stay stable, req_ready stays 0, and a new req_valid is ignored until the handshake completes.
- Assert rst_n=0 during beat 10 of a read:
  - mem_en drops immediately and all outputs take reset values;
  - the next read completes correctly.
